// File: rtl/vga_draw_arbiter_if.sv
// Draw-port bundle between the pixel-draw clients and vga_draw_arbiter.
// master = client side (requests/pixels), slave = arbiter side (grant/VGA outputs).
interface vga_draw_arbiter_if #(
    parameter int NUM_CLIENTS = 3,
    parameter int X_W         = 9,
    parameter int Y_W         = 8,
    parameter int COLOR_W     = 3
);
    logic [NUM_CLIENTS-1:0]         req;
    logic [NUM_CLIENTS-1:0]         cl_plot;
    logic [NUM_CLIENTS*X_W-1:0]     cl_x;
    logic [NUM_CLIENTS*Y_W-1:0]     cl_y;
    logic [NUM_CLIENTS*COLOR_W-1:0] cl_color;
    logic [NUM_CLIENTS-1:0]         grant;
    logic                           plot;
    logic [X_W-1:0]                 x;
    logic [Y_W-1:0]                 y;
    logic [COLOR_W-1:0]             color;
    logic                           busy;
    logic                           timeout;

    modport master (
        output req, cl_plot, cl_x, cl_y, cl_color,
        input  grant, plot, x, y, color, busy, timeout
    );

    modport slave (
        input  req, cl_plot, cl_x, cl_y, cl_color,
        output grant, plot, x, y, color, busy, timeout
    );
endinterface

// File: rtl/vga_draw_arbiter.sv
// N-way pixel-draw arbiter with burst locking, fixed-priority or round-robin selection
// and registered VGA outputs. Define DRAW_TIMEOUT_EN to add the grant hold-time limit.
module vga_draw_arbiter #(
    parameter int NUM_CLIENTS = 3,
    parameter int X_W         = 9,
    parameter int Y_W         = 8,
    parameter int COLOR_W     = 3,
    parameter int RR_MODE     = 0,
    parameter int TIMEOUT     = 65535
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    vga_draw_arbiter_if.slave    bus
);
    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_OWN = 1'b1} state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       owner_q, ptr_q;
    logic [NUM_CLIENTS-1:0] grant_q;
    logic                   plot_q, busy_q, timeout_q;
    logic [X_W-1:0]         x_q;
    logic [Y_W-1:0]         y_q;
    logic [COLOR_W-1:0]     color_q;

    logic [NUM_CLIENTS-1:0] req_eff;
    logic [IDX_W-1:0]       win_idx, rr_idx, next_ptr;
    logic                   win_found;
    logic                   own_req, own_plot;
    logic [X_W-1:0]         own_x;
    logic [Y_W-1:0]         own_y;
    logic [COLOR_W-1:0]     own_color;
    logic                   force_rel, warn_tick;
    int                     rr_j;

    always_comb begin
        own_req   = bus.req[owner_q];
        own_plot  = bus.cl_plot[owner_q];
        own_x     = bus.cl_x[owner_q*X_W +: X_W];
        own_y     = bus.cl_y[owner_q*Y_W +: Y_W];
        own_color = bus.cl_color[owner_q*COLOR_W +: COLOR_W];
        next_ptr  = (owner_q == IDX_W'(NUM_CLIENTS-1)) ? '0 : owner_q + 1'b1;
    end

    // Fixed mode: last hit of the upward scan is the highest index.
    // RR mode: first hit scanning upward from the pointer with wrap.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        rr_j      = 0;
        rr_idx    = '0;
        if (RR_MODE == 0) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (req_eff[i]) begin
                    win_idx   = IDX_W'(i);
                    win_found = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < NUM_CLIENTS; k++) begin
                rr_j = int'(ptr_q) + k;
                if (rr_j >= NUM_CLIENTS) rr_j = rr_j - NUM_CLIENTS;
                rr_idx = IDX_W'(rr_j);
                if (!win_found && req_eff[rr_idx]) begin
                    win_idx   = rr_idx;
                    win_found = 1'b1;
                end
            end
        end
    end

`ifdef DRAW_TIMEOUT_EN
    logic [15:0]            hold_q;
    logic [NUM_CLIENTS-1:0] mask_q;

    assign req_eff   = bus.req & ~mask_q;
    assign force_rel = (state_q == S_OWN) && own_req && (hold_q == 16'(TIMEOUT-1));
    // Pulse lands in the last OWN cycle, one edge ahead of the forced release.
    assign warn_tick = (state_q == S_OWN) && own_req && (hold_q == 16'(TIMEOUT-2));

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            hold_q <= '0;
            mask_q <= '0;
        end else begin
            hold_q <= (state_q == S_OWN) ? hold_q + 16'd1 : 16'd0;
            mask_q <= (mask_q & bus.req) |
                      (force_rel ? (NUM_CLIENTS'(1) << owner_q) : '0);
        end
    end
`else
    assign req_eff   = bus.req;
    assign force_rel = 1'b0;
    assign warn_tick = 1'b0;
`endif

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            color_q   <= '0;
        end else begin
            timeout_q <= warn_tick;
            case (state_q)
                S_IDLE: begin
                    plot_q <= 1'b0;
                    if (win_found) begin
                        owner_q <= win_idx;
                        grant_q <= NUM_CLIENTS'(1) << win_idx;
                        busy_q  <= 1'b1;
                        state_q <= S_OWN;
                    end
                end
                S_OWN: begin
                    if (!own_req || force_rel) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        plot_q  <= 1'b0;
                        state_q <= S_IDLE;
                        if (RR_MODE != 0) ptr_q <= next_ptr;
                    end else begin
                        plot_q <= own_plot;
                        if (own_plot) begin
                            x_q     <= own_x;
                            y_q     <= own_y;
                            color_q <= own_color;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.grant   = grant_q;
    assign bus.plot    = plot_q;
    assign bus.x       = x_q;
    assign bus.y       = y_q;
    assign bus.color   = color_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;
endmodule
